// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage.
// The result is computed at accept time and held in pending registers until the busy window elapses.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic              pend_we_q, pend_we_d;

  // Datapath: evaluated every cycle, only captured at the accepting edge.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

  always_comb begin
    prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u   = {32'd0, A} * {32'd0, B};
    a_neg    = (op == OP_DIV) & A[31];
    b_neg    = (op == OP_DIV) & B[31];
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    div_zero = (B == 32'd0);
    // Divisor forced to 1 on divide-by-zero so the datapath never produces X.
    b_safe   = div_zero ? 32'd1 : b_mag;
    uq       = a_mag / b_safe;
    ur       = a_mag % b_safe;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    quo      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem      = a_neg ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_we_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_we_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quo;
              pend_we_d = ~div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
